// File: rtl/icb_pkg.sv
// Shared ICB definitions for the two-master arbiter: field widths, the
// master id type and the fixed master numbering.
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;

    // One bit is enough to name either of the two masters.
    typedef logic mid_t;

    localparam mid_t M_CPU  = 1'b0;
    localparam mid_t M_CONV = 1'b1;

    // The opposite master, used when round-robin hands contention to
    // whoever lost the previous handshake.
    function automatic mid_t other_mid(input mid_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/icb_arb2_if.sv
// ICB port bundle: command channel (valid/ready/addr/read/wdata/wmask) and
// response channel (valid/ready/rdata). The master modport issues commands,
// the slave modport accepts them.
interface icb_if
    import icb_pkg::*;
#(
    parameter int AW = ICB_AW,
    parameter int DW = ICB_DW
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

endinterface

// File: rtl/icb_ord_fifo.sv
// Small synchronous FIFO recording the issue order of outstanding commands.
// The head is read combinationally so the response path has no latency.
// Pushes while full and pops while empty are ignored.
module icb_ord_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/icb_arb2.sv
// Two-master ICB arbiter: m0 (CPU) and m1 (conv engine) share one ICB slave.
// Commands pass through combinationally; an order FIFO remembers which
// master owns each outstanding command so in-order responses are routed back.
// Build option: define ICB_ARB2_RR_EN for round-robin contention handling;
// otherwise m0 has fixed priority.
module icb_arb2
    import icb_pkg::*;
#(
    parameter int OUTS_DEPTH = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic     clk,
    input  logic     rst,
    icb_if.slave     m0,
    icb_if.slave     m1,
    icb_if.master    s,
    output logic     err
);
    localparam int CW = $clog2(OUTS_DEPTH);
    localparam logic [CW:0] MAX_CNT = (CW+1)'(OUTS_DEPTH);

    logic            r_hold_vld;
    mid_t            r_hold_id;
    logic            r_err;
`ifdef ICB_ARB2_RR_EN
    mid_t            r_rr_last;
`endif

    logic [1:0]      w_req;
    logic [1:0]      w_cmd_ready;
    logic [1:0]      w_rsp_valid;
    logic [1:0]      w_rsp_ready_in;
    mid_t            w_grant;
    mid_t            w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW:0]     w_fifo_count;
    logic            w_cmd_hs;
    logic            w_rsp_hs;
    logic            w_rsp_drop;

    assign w_req          = {m1.icb_cmd_valid, m0.icb_cmd_valid};
    assign w_rsp_ready_in = {m1.icb_rsp_ready, m0.icb_rsp_ready};

    // Grant selection: a presented-but-unaccepted command keeps its grant,
    // otherwise contention is resolved by priority or round-robin.
    always_comb begin
        w_grant = M_CPU;
        if (r_hold_vld) begin
            w_grant = r_hold_id;
        end else if (w_req == 2'b11) begin
`ifdef ICB_ARB2_RR_EN
            w_grant = other_mid(r_rr_last);
`else
            w_grant = M_CPU;
`endif
        end else if (w_req[1]) begin
            w_grant = M_CONV;
        end
    end

    // Command path: granted master straight to the slave, masked while full.
    assign s.icb_cmd_valid = w_req[w_grant] & ~w_fifo_full;
    assign s.icb_cmd_addr  = (w_grant == M_CONV) ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
    assign s.icb_cmd_read  = (w_grant == M_CONV) ? m1.icb_cmd_read  : m0.icb_cmd_read;
    assign s.icb_cmd_wdata = (w_grant == M_CONV) ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
    assign s.icb_cmd_wmask = (w_grant == M_CONV) ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;

    assign w_cmd_hs   = s.icb_cmd_valid & s.icb_cmd_ready;
    assign w_rsp_hs   = s.icb_rsp_valid & s.icb_rsp_ready & ~w_fifo_empty;
    assign w_rsp_drop = s.icb_rsp_valid & w_fifo_empty;

    // Per-master ready and response-valid: only the granted master sees
    // cmd_ready, only the FIFO-head owner sees rsp_valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign w_cmd_ready[gi] = (w_grant == mid_t'(gi)) & s.icb_cmd_ready & ~w_fifo_full;
            assign w_rsp_valid[gi] = s.icb_rsp_valid & ~w_fifo_empty & (w_head == mid_t'(gi));
        end
    endgenerate

    assign m0.icb_cmd_ready = w_cmd_ready[0];
    assign m1.icb_cmd_ready = w_cmd_ready[1];
    assign m0.icb_rsp_valid = w_rsp_valid[0];
    assign m1.icb_rsp_valid = w_rsp_valid[1];
    assign m0.icb_rsp_rdata = s.icb_rsp_rdata;
    assign m1.icb_rsp_rdata = s.icb_rsp_rdata;

    // An orphan response (nothing outstanding) is swallowed so the slave
    // cannot stall; ready only rises while such a response is offered.
    assign s.icb_rsp_ready = w_fifo_empty ? s.icb_rsp_valid : w_rsp_ready_in[w_head];

    icb_ord_fifo #(
        .WIDTH (1),
        .DEPTH (OUTS_DEPTH)
    ) u_ord_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cmd_hs),
        .i_pop   (w_rsp_hs),
        .i_din   (w_grant),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Grant hold and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
            r_hold_id  <= M_CPU;
            r_err      <= 1'b0;
        end else begin
            r_hold_vld <= s.icb_cmd_valid & ~s.icb_cmd_ready;
            r_hold_id  <= w_grant;
            if (w_rsp_drop) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef ICB_ARB2_RR_EN
    // Remember the last master to win a handshake; reset value makes m0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= M_CONV;
        end else if (w_cmd_hs) begin
            r_rr_last <= w_grant;
        end
    end
`endif

    assign err = r_err;

    // Occupancy can never exceed the configured depth.
    a_count_range: assert property (@(posedge clk) disable iff (rst) (w_fifo_count <= MAX_CNT));

endmodule

// File: doc/icb_arb2.md
# icb_arb2

Two-master ICB arbiter sharing one ICB slave port (the SRAM/peripheral bus) between the CPU master (m0) and the convolution engine master (m1). It accepts at most one command per cycle and tracks outstanding commands in an order FIFO. Each in-order response is returned to the master that issued the command. It sits between the `conv` ICB master port, the CPU data-side ICB, and the shared memory slave.

## Interface
- `OUTS_DEPTH`, default 4: maximum outstanding commands; power of two, at least 2.
- `AW`, default 32: address width.
- `DW`, default 32: data width; mask width is DW/8.
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `mN_icb_cmd_valid`, in, 1: master N command valid (N = 0, 1).
- `mN_icb_cmd_ready`, out, 1: command accepted.
- `mN_icb_cmd_addr`, in, AW: command address.
- `mN_icb_cmd_read`, in, 1: 1 = read, 0 = write.
- `mN_icb_cmd_wdata`, in, DW: write data.
- `mN_icb_cmd_wmask`, in, DW/8: byte write mask.
- `mN_icb_rsp_valid`, out, 1: response valid.
- `mN_icb_rsp_ready`, in, 1: master accepts the response.
- `mN_icb_rsp_rdata`, out, DW: response read data.
- `s_icb_cmd_valid/ready/addr/read/wdata/wmask`, out/in/out/out/out/out: slave command channel, same widths as the master ports.
- `s_icb_rsp_valid/ready/rdata`, in/out/in: slave response channel.
- `err`, out, 1: sticky protocol error flag.

## Operation
- **Arbitration** is combinational among the masters whose cmd_valid is high. The selected master's cmd fields are muxed to the slave port. `s_icb_cmd_valid` = the selected master's valid AND NOT fifo_full.
- **Grant hold:**
  - If the slave port presents valid without a handshake, a `hold` register latches the granted index.
  - The next cycle's grant is forced to that index until the handshake `s_icb_cmd_valid & s_icb_cmd_ready`.
  - A presented command is never switched or withdrawn.
- **Command ready:** `mN_icb_cmd_ready` = (grant==N) & s_icb_cmd_ready & NOT fifo_full. The non-granted master sees ready=0.
- **Order FIFO:** OUTS_DEPTH entries, 1 bit each (master id).
  - Push the grant index on every slave cmd handshake.
  - Pop on every slave rsp handshake.
  - Read and write pointers are log2(OUTS_DEPTH) bits and wrap naturally; count is log2(OUTS_DEPTH)+1 bits.
- **Response routing:**
  - id = FIFO head. `m[id]_icb_rsp_valid` = s_icb_rsp_valid & NOT fifo_empty; the other master's rsp_valid = 0.
  - `s_icb_rsp_ready` = `m[id]_icb_rsp_ready`.
  - rdata is broadcast to both masters.
- **Boundary conditions:**
  - FIFO full: no new command is presented to the slave (valid masked). A pop in the same cycle does not unblock the push; the new command goes out next cycle.
  - FIFO empty with s_icb_rsp_valid: `s_icb_rsp_ready`=1 (the response is dropped), `err` is set, both master rsp_valid are 0.
  - Push and pop in the same cycle when not full: count unchanged, both pointers advance.
  - Reset asserted mid-transaction: FIFO, hold and rr state are cleared. Outstanding slave responses are then treated as the empty-FIFO case above.

## Timing
- Command path is zero-latency: master to slave combinationally, with no bubble when the FIFO is not full.
- Response path is zero-latency, combinational.
- Back-to-back commands from alternating masters are accepted on consecutive cycles.
- Reset values:
  - all ready/valid outputs 0 (combinational, derived from cleared state and inputs);
  - `err`=0, count=0, hold inactive, rr pointer = m0 preferred.
- State: `hold_vld`, `hold_id`, `rr_last`, the FIFO array, pointers and count, and `err`. All state updates on the rising edge of `clk`.

## Configuration
- `ICB_ARB2_RR_EN` defined: round-robin arbitration. On contention, the master not granted at the last cmd handshake wins. `rr_last` updates on every handshake.
- `ICB_ARB2_RR_EN` undefined: fixed priority, m0 (CPU) always wins contention. `rr_last` is not implemented.
- Grant hold applies in both modes.

## Structure
- Package `icb_pkg`:
  - ICB command and response field widths;
  - `typedef` for the master id;
  - constants `M_CPU`=0 and `M_CONV`=1.
- Sub-module `icb_ord_fifo`: parameterised sync FIFO (WIDTH, DEPTH) with full, empty and count outputs. The arbiter instantiates it with WIDTH=1.

## Test plan
- **Single-master reads:** m1 issues 4 reads to 0x4000_0000..0x4000_000C with the slave always ready. Required: 4 handshakes on consecutive cycles. Slave returns rdata 0xA0..0xA3, and m1 receives those responses in order while m0 rsp_valid stays 0.
- **Contention:** m0 and m1 both valid every cycle, slave always ready. With RR_EN, grants alternate m0,m1,m0,m1…. Without RR_EN, 8 consecutive m0 grants.
- **Grant hold:** m1 is granted with s_icb_cmd_ready held 0 for 3 cycles, and m0 raises valid in cycle 1. Required: the slave port keeps m1's address stable for all 3 cycles, and m0 is granted only after m1's handshake.
- **FIFO full:** OUTS_DEPTH=4, 4 accepted commands with no responses. Required: the 5th command sees s_icb_cmd_valid=0 and cmd_ready=0. After one response handshake, the 5th command is accepted the following cycle.
- **Interleaved routing:** commands issued in the order m0,m1,m1,m0 with responses 0x11,0x22,0x33,0x44. Required: m0 gets 0x11 and 0x44, m1 gets 0x22 and 0x33. m1 rsp_ready=0 for 2 cycles stalls `s_icb_rsp_ready`.
- **Error and reset:** s_icb_rsp_valid pulsed with an empty FIFO sets `err`=1, and `err` stays 1 until `rst`. Asserting `rst` for 1 cycle with 2 commands outstanding returns count, `err` and hold to 0.
